// File: rtl/mmio_timer_intc.sv
// mmio_timer_intc
// Memory-mapped down-counting timer plus a 5-source interrupt pending/mask
// unit. It sits on the core's data-memory bus next to data RAM.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   ce_i       bus access enable
//   we_i       1 = write, 0 = read
//   addr_i     byte address (bits [1:0] ignored, [7:2] select register)
//   sel_i      write byte enables, sel_i[3] covers bits 31:24
//   data_i     write data
//   data_o     read data, combinational (the MEM stage samples it in-cycle)
//   hit_o      ce_i && address inside the 256-byte window, combinational
//   ext_irq_i  asynchronous external interrupt lines, active-high
//   int_o      registered interrupt request to the core (bit 5 always 0)
//
// Register map (word offsets):
//   0x00 CTRL  RW  bit0 EN, bit1 AUTO
//   0x04 LOAD  RW  32-bit reload value; a write also loads COUNT
//   0x08 COUNT RO
//   0x0C PEND  W1C bit0 timer, bits4:1 ext[3:0]
//   0x10 MASK  RW  bits4:0
//   0x14 RAW   RO  bits3:0 synchronized external levels
module mmio_timer_intc #(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        hit_o,
    input  logic [3:0]  ext_irq_i,
    output logic [5:0]  int_o
);

    localparam logic [5:0]  OFF_CTRL  = 6'h00;
    localparam logic [5:0]  OFF_LOAD  = 6'h01;
    localparam logic [5:0]  OFF_COUNT = 6'h02;
    localparam logic [5:0]  OFF_PEND  = 6'h03;
    localparam logic [5:0]  OFF_MASK  = 6'h04;
    localparam logic [5:0]  OFF_RAW   = 6'h05;
    localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

    // Architectural state
    logic        ctrl_en_q,   ctrl_en_d;
    logic        ctrl_auto_q, ctrl_auto_d;
    logic [31:0] load_q,      load_d;
    logic [31:0] count_q,     count_d;
    logic [4:0]  pend_q,      pend_d;
    logic [4:0]  mask_q,      mask_d;
    logic [15:0] presc_q,     presc_d;
    logic [4:0]  int_q;

    // External-line synchronizer and edge-detect history
    logic [3:0]  sync1_q;
    logic [3:0]  sync2_q;
    logic [3:0]  ext_dly_q;

    // Bus decode
    logic        hit;
    logic        wr_en;
    logic [5:0]  reg_idx;
    logic        wr_ctrl;
    logic        wr_load;
    logic        wr_pend;
    logic        wr_mask;
    logic [31:0] load_wr_val;

    // Timer / interrupt events
    logic        tick;
    logic        expire;
    logic [3:0]  ext_rise;
    logic [4:0]  pend_set;
    logic [4:0]  pend_clr;

    // Address bits [1:0] carry no meaning for word registers.
    logic        unused_addr_lsb;
    assign unused_addr_lsb = ^addr_i[1:0];

    assign hit     = ce_i && (addr_i[31:8] == BASE_ADDR[31:8]);
    assign hit_o   = hit;
    assign wr_en   = hit && we_i;
    assign reg_idx = addr_i[7:2];

    // CTRL, PEND and MASK only have bits in byte 0, so byte 0's enable gates them.
    assign wr_ctrl = wr_en && (reg_idx == OFF_CTRL) && sel_i[0];
    assign wr_load = wr_en && (reg_idx == OFF_LOAD);
    assign wr_pend = wr_en && (reg_idx == OFF_PEND) && sel_i[0];
    assign wr_mask = wr_en && (reg_idx == OFF_MASK) && sel_i[0];

    // Byte-merged LOAD value; reused to seed COUNT on the same edge.
    for (genvar gi = 0; gi < 4; gi++) begin : g_load_bytes
        assign load_wr_val[8*gi +: 8] = sel_i[gi] ? data_i[8*gi +: 8] : load_q[8*gi +: 8];
    end

    assign tick     = ctrl_en_q && (presc_q == PRESC_LAST);
    assign expire   = tick && (count_q == 32'd1);
    assign ext_rise = sync2_q & ~ext_dly_q;
    assign pend_set = {ext_rise, expire};
    assign pend_clr = wr_pend ? data_i[4:0] : 5'd0;

    always_comb begin
        // Prescaler restarts on a LOAD write and idles at 0 while disabled.
        presc_d = presc_q + 16'd1;
        if (wr_load || !ctrl_en_q || tick) begin
            presc_d = 16'd0;
        end

        // Timer step uses the pre-write EN/AUTO; a COUNT of 0 never expires.
        count_d     = count_q;
        ctrl_en_d   = ctrl_en_q;
        ctrl_auto_d = ctrl_auto_q;
        if (tick && (count_q != 32'd0)) begin
            if (count_q != 32'd1) begin
                count_d = count_q - 32'd1;
            end else if (ctrl_auto_q) begin
                count_d = load_q;
            end else begin
                count_d   = 32'd0;
                ctrl_en_d = 1'b0;
            end
        end

        // Bus writes override the timer's own updates.
        if (wr_load) begin
            count_d = load_wr_val;
        end
        if (wr_ctrl) begin
            ctrl_en_d   = data_i[0];
            ctrl_auto_d = data_i[1];
        end

        load_d = wr_load ? load_wr_val : load_q;
        mask_d = wr_mask ? data_i[4:0] : mask_q;

        // Hardware set beats a software clear landing on the same edge.
        pend_d = (pend_q & ~pend_clr) | pend_set;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_en_q   <= 1'b0;
            ctrl_auto_q <= 1'b0;
            load_q      <= 32'd0;
            count_q     <= 32'd0;
            pend_q      <= 5'd0;
            mask_q      <= 5'd0;
            presc_q     <= 16'd0;
            int_q       <= 5'd0;
            sync1_q     <= 4'd0;
            sync2_q     <= 4'd0;
            ext_dly_q   <= 4'd0;
        end else begin
            ctrl_en_q   <= ctrl_en_d;
            ctrl_auto_q <= ctrl_auto_d;
            load_q      <= load_d;
            count_q     <= count_d;
            pend_q      <= pend_d;
            mask_q      <= mask_d;
            presc_q     <= presc_d;
            int_q       <= pend_q & mask_q;
            sync1_q     <= ext_irq_i;
            sync2_q     <= sync1_q;
            ext_dly_q   <= sync2_q;
        end
    end

    assign int_o = {1'b0, int_q};

    always_comb begin
        data_o = 32'd0;
        if (hit && !we_i) begin
            case (reg_idx)
                OFF_CTRL:  data_o = {30'd0, ctrl_auto_q, ctrl_en_q};
                OFF_LOAD:  data_o = load_q;
                OFF_COUNT: data_o = count_q;
                OFF_PEND:  data_o = {27'd0, pend_q};
                OFF_MASK:  data_o = {27'd0, mask_q};
                OFF_RAW:   data_o = {28'd0, sync2_q};
                default:   data_o = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_timer_intc.sv
// Bench for mmio_timer_intc. Two instances share one bus: dut0 with a
// prescale of 1 and dut1 with a prescale of 4. Directed scenarios check
// constants taken from the register behaviour; a random phase compares both
// instances against a cycle-level reference model every cycle.
module tb_mmio_timer_intc;

    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [31:0] A_CTRL  = BASE + 32'h00;
    localparam logic [31:0] A_LOAD  = BASE + 32'h04;
    localparam logic [31:0] A_COUNT = BASE + 32'h08;
    localparam logic [31:0] A_PEND  = BASE + 32'h0C;
    localparam logic [31:0] A_MASK  = BASE + 32'h10;
    localparam logic [31:0] A_RAW   = BASE + 32'h14;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [3:0]  sel = 4'd0;
    logic [31:0] wdata = 32'd0;
    logic [3:0]  ext = 4'd0;
    logic [31:0] d0, d1;
    logic        h0, h1;
    logic [5:0]  i0, i1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mmio_timer_intc #(.BASE_ADDR(BASE), .PRESCALE(1)) u_dut0 (
        .clk(clk), .rst(rst), .ce_i(ce), .we_i(we), .addr_i(addr), .sel_i(sel),
        .data_i(wdata), .data_o(d0), .hit_o(h0), .ext_irq_i(ext), .int_o(i0)
    );

    mmio_timer_intc #(.BASE_ADDR(BASE), .PRESCALE(4)) u_dut1 (
        .clk(clk), .rst(rst), .ce_i(ce), .we_i(we), .addr_i(addr), .sel_i(sel),
        .data_i(wdata), .data_o(d1), .hit_o(h1), .ext_irq_i(ext), .int_o(i1)
    );

    // ---------------- reference model ----------------
    logic        m_en    [2];
    logic        m_auto  [2];
    logic [31:0] m_load  [2];
    logic [31:0] m_count [2];
    logic [4:0]  m_pend  [2];
    logic [4:0]  m_mask  [2];
    logic [4:0]  m_int   [2];
    int          m_phase [2];   // cycles elapsed within the current tick period
    logic [3:0]  m_hist  [3];   // ext samples: [0] latest edge, [1] one edge older, [2] two older

    function automatic int psc(input int v);
        return (v == 0) ? 1 : 4;
    endfunction

    task automatic model_reset();
        for (int v = 0; v < 2; v++) begin
            m_en[v] = 0; m_auto[v] = 0; m_load[v] = 0; m_count[v] = 0;
            m_pend[v] = 0; m_mask[v] = 0; m_int[v] = 0; m_phase[v] = 0;
        end
        for (int k = 0; k < 3; k++) m_hist[k] = 4'd0;
    endtask

    function automatic logic model_hit();
        return ce && (addr[31:8] == BASE[31:8]);
    endfunction

    function automatic logic [31:0] model_data(input int v);
        if (!(model_hit() && !we)) return 32'd0;
        case (addr[7:2])
            6'd0: return {30'd0, m_auto[v], m_en[v]};
            6'd1: return m_load[v];
            6'd2: return m_count[v];
            6'd3: return {27'd0, m_pend[v]};
            6'd4: return {27'd0, m_mask[v]};
            6'd5: return {28'd0, m_hist[1]};
            default: return 32'd0;
        endcase
    endfunction

    // Advances the model by one rising edge using the bus inputs now applied.
    task automatic model_step();
        logic       wr;
        logic [3:0] rise;
        wr   = model_hit() && we;
        // An input seen high two edges ago but low three edges ago is a new edge.
        rise = m_hist[1] & ~m_hist[2];
        for (int v = 0; v < 2; v++) begin
            logic        tick, en_n, auto_n;
            logic [31:0] cnt_n, ld_n;
            logic [4:0]  pend_n, mask_n, setv;
            int          ph_n;
            tick   = m_en[v] && (m_phase[v] == psc(v) - 1);
            en_n   = m_en[v];
            auto_n = m_auto[v];
            cnt_n  = m_count[v];
            ld_n   = m_load[v];
            mask_n = m_mask[v];
            pend_n = m_pend[v];
            setv   = {rise, 1'b0};
            ph_n   = (m_en[v] && !tick) ? m_phase[v] + 1 : 0;
            if (tick && m_count[v] != 0) begin
                if (m_count[v] > 1) begin
                    cnt_n = m_count[v] - 1;
                end else begin
                    setv[0] = 1'b1;
                    if (m_auto[v]) cnt_n = m_load[v];
                    else begin cnt_n = 0; en_n = 0; end
                end
            end
            if (wr) begin
                case (addr[7:2])
                    6'd0: if (sel[0]) begin en_n = wdata[0]; auto_n = wdata[1]; end
                    6'd1: begin
                        for (int b = 0; b < 4; b++)
                            if (sel[b]) ld_n[8*b +: 8] = wdata[8*b +: 8];
                        cnt_n = ld_n;
                        ph_n  = 0;
                    end
                    6'd3: if (sel[0]) pend_n = pend_n & ~wdata[4:0];
                    6'd4: if (sel[0]) mask_n = wdata[4:0];
                    default: ;
                endcase
            end
            pend_n = pend_n | setv;
            m_int[v]   = m_pend[v] & m_mask[v];
            m_en[v]    = en_n;
            m_auto[v]  = auto_n;
            m_count[v] = cnt_n;
            m_load[v]  = ld_n;
            m_pend[v]  = pend_n;
            m_mask[v]  = mask_n;
            m_phase[v] = ph_n;
        end
        m_hist[2] = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = ext;
    endtask

    // ---------------- bus helpers ----------------
    task automatic bus_idle();
        ce = 0; we = 0; addr = 32'd0; sel = 4'd0; wdata = 32'd0;
    endtask

    // One clock: model steps on the inputs present, then return at the falling edge.
    task automatic advance();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        ce = 1; we = 1; addr = a; wdata = d; sel = s;
        advance();
        bus_idle();
    endtask

    task automatic rd(input logic [31:0] a);
        ce = 1; we = 0; addr = a; sel = 4'd0; wdata = 32'd0;
        #1;
    endtask

    task automatic do_reset();
        bus_idle();
        ext = 4'd0;
        rst = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1;
        advance();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] regs [5];
        regs = '{A_CTRL, A_LOAD, A_COUNT, A_PEND, A_MASK};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            rd(regs[k]);
            vectors++;
            if (d0 !== 32'd0 || d1 !== 32'd0) begin
                miscompares++;
                $display("FAIL reset_reg %h: got %h/%h expected 0", regs[k], d0, d1);
            end
        end
        vectors++;
        if (i0 !== 6'd0 || i1 !== 6'd0) begin
            miscompares++;
            $display("FAIL reset_int: got %b/%b expected 0", i0, i1);
        end
        rd(32'h1000_0100);
        vectors++;
        if (h0 !== 1'b0 || d0 !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_miss: got hit=%b data=%h expected hit=0 data=0", h0, d0);
        end
        bus_idle();
    endtask

    task automatic test_oneshot();
        do_reset();
        wr(A_LOAD, 32'd5, 4'hF);
        wr(A_MASK, 32'd1, 4'hF);
        wr(A_CTRL, 32'd1, 4'hF);
        for (int k = 0; k < 5; k++) begin
            rd(A_COUNT);
            vectors++;
            if (d0 !== 32'(5 - k)) begin
                miscompares++;
                $display("FAIL oneshot_count[%0d]: got %0d expected %0d", k, d0, 5 - k);
            end
            advance();
        end
        rd(A_COUNT);
        vectors++;
        if (d0 !== 32'd0) begin miscompares++; $display("FAIL oneshot_count_end: got %0d expected 0", d0); end
        rd(A_PEND);
        vectors++;
        if (d0 !== 32'd1) begin miscompares++; $display("FAIL oneshot_pend: got %h expected 1", d0); end
        rd(A_CTRL);
        vectors++;
        if (d0 !== 32'd0) begin miscompares++; $display("FAIL oneshot_en_clear: got %h expected 0", d0); end
        vectors++;
        if (i0 !== 6'd0) begin miscompares++; $display("FAIL oneshot_int_early: got %b expected 000000", i0); end
        bus_idle();
        advance();
        vectors++;
        if (i0 !== 6'b000001) begin miscompares++; $display("FAIL oneshot_int: got %b expected 000001", i0); end
    endtask

    task automatic test_autoreload();
        do_reset();
        wr(A_MASK, 32'd1, 4'hF);
        wr(A_LOAD, 32'd3, 4'hF);
        wr(A_CTRL, 32'd3, 4'hF);
        advance();
        advance();
        rd(A_PEND);
        vectors++;
        if (d0 !== 32'd0) begin miscompares++; $display("FAIL auto_pend_early: got %h expected 0", d0); end
        bus_idle();
        advance();
        rd(A_PEND);
        vectors++;
        if (d0 !== 32'd1) begin miscompares++; $display("FAIL auto_pend_set: got %h expected 1", d0); end
        rd(A_COUNT);
        vectors++;
        if (d0 !== 32'd3) begin miscompares++; $display("FAIL auto_reload: got %0d expected 3", d0); end
        rd(A_CTRL);
        vectors++;
        if (d0 !== 32'd3) begin miscompares++; $display("FAIL auto_en_kept: got %h expected 3", d0); end
        wr(A_PEND, 32'd1, 4'hF);
        rd(A_PEND);
        vectors++;
        if (d0 !== 32'd0) begin miscompares++; $display("FAIL auto_w1c: got %h expected 0", d0); end
        vectors++;
        if (i0 !== 6'b000001) begin miscompares++; $display("FAIL auto_int_lag: got %b expected 000001", i0); end
        bus_idle();
        advance();
        vectors++;
        if (i0 !== 6'd0) begin miscompares++; $display("FAIL auto_int_drop: got %b expected 000000", i0); end
        advance();
        rd(A_PEND);
        vectors++;
        if (d0 !== 32'd1) begin miscompares++; $display("FAIL auto_second_expiry: got %h expected 1", d0); end
        bus_idle();
    endtask

    task automatic test_ext_edge();
        do_reset();
        wr(A_MASK, 32'h1E, 4'hF);
        ext = 4'b0100;
        for (int k = 1; k <= 3; k++) begin
            advance();
            rd(A_PEND);
            vectors++;
            if (d0 !== ((k == 3) ? 32'h08 : 32'h00)) begin
                miscompares++;
                $display("FAIL ext_pend_cycle%0d: got %h expected %h", k, d0, (k == 3) ? 32'h08 : 32'h00);
            end
            rd(A_RAW);
            vectors++;
            if (d0 !== ((k >= 2) ? 32'h4 : 32'h0)) begin
                miscompares++;
                $display("FAIL ext_raw_cycle%0d: got %h expected %h", k, d0, (k >= 2) ? 32'h4 : 32'h0);
            end
        end
        bus_idle();
        advance();
        vectors++;
        if (i0 !== 6'b001000) begin miscompares++; $display("FAIL ext_int: got %b expected 001000", i0); end
        // Clear while the line is still high: a steady level must not re-set it.
        wr(A_PEND, 32'h08, 4'h1);
        repeat (5) advance();
        rd(A_PEND);
        vectors++;
        if (d0 !== 32'd0) begin miscompares++; $display("FAIL ext_level_no_reset: got %h expected 0", d0); end
        rd(A_RAW);
        vectors++;
        if (d0 !== 32'h4) begin miscompares++; $display("FAIL ext_raw_high: got %h expected 4", d0); end
        bus_idle();
        ext = 4'd0;
        repeat (3) advance();
        rd(A_RAW);
        vectors++;
        if (d0 !== 32'h0) begin miscompares++; $display("FAIL ext_raw_low: got %h expected 0", d0); end
        bus_idle();
    endtask

    task automatic test_byte_w1c();
        do_reset();
        wr(A_LOAD, 32'hAABB_CCDD, 4'b0011);
        rd(A_LOAD);
        vectors++;
        if (d0 !== 32'h0000_CCDD) begin miscompares++; $display("FAIL byte_load: got %h expected 0000ccdd", d0); end
        rd(A_COUNT);
        vectors++;
        if (d0 !== 32'h0000_CCDD) begin miscompares++; $display("FAIL byte_count: got %h expected 0000ccdd", d0); end
        bus_idle();
        wr(A_LOAD, 32'd2, 4'hF);
        wr(A_CTRL, 32'd1, 4'hF);
        advance();
        wr(A_PEND, 32'd1, 4'hF);        // lands on the expiry edge
        rd(A_PEND);
        vectors++;
        if (d0 !== 32'd1) begin miscompares++; $display("FAIL w1c_race: got %h expected 1", d0); end
        wr(A_PEND, 32'd1, 4'b1110);     // byte 0 disabled: no clear
        rd(A_PEND);
        vectors++;
        if (d0 !== 32'd1) begin miscompares++; $display("FAIL w1c_sel_off: got %h expected 1", d0); end
        wr(A_PEND, 32'd1, 4'b0001);
        rd(A_PEND);
        vectors++;
        if (d0 !== 32'd0) begin miscompares++; $display("FAIL w1c_clear: got %h expected 0", d0); end
        bus_idle();
        wr(A_LOAD, 32'd4, 4'hF);
        wr(A_CTRL, 32'd3, 4'hF);
        repeat (3) advance();
        rd(A_COUNT);
        vectors++;
        if (d0 !== 32'd1) begin miscompares++; $display("FAIL load_race_pre: got %0d expected 1", d0); end
        wr(A_LOAD, 32'd9, 4'hF);        // lands on the expiry edge
        rd(A_COUNT);
        vectors++;
        if (d0 !== 32'd9) begin miscompares++; $display("FAIL load_race_count: got %0d expected 9", d0); end
        rd(A_PEND);
        vectors++;
        if (d0 !== 32'd1) begin miscompares++; $display("FAIL load_race_pend: got %h expected 1", d0); end
        bus_idle();
    endtask

    task automatic test_prescaler_reset();
        logic [31:0] exp_cnt;
        do_reset();
        wr(A_LOAD, 32'd2, 4'hF);
        wr(A_MASK, 32'd1, 4'hF);
        wr(A_CTRL, 32'd1, 4'hF);
        for (int k = 1; k <= 8; k++) begin
            advance();
            exp_cnt = (k < 4) ? 32'd2 : ((k < 8) ? 32'd1 : 32'd0);
            rd(A_COUNT);
            vectors++;
            if (d1 !== exp_cnt) begin
                miscompares++;
                $display("FAIL presc_count_cycle%0d: got %0d expected %0d", k, d1, exp_cnt);
            end
            rd(A_PEND);
            vectors++;
            if (d1 !== ((k == 8) ? 32'd1 : 32'd0)) begin
                miscompares++;
                $display("FAIL presc_pend_cycle%0d: got %h expected %0d", k, d1, (k == 8) ? 1 : 0);
            end
            bus_idle();
        end
        advance();
        vectors++;
        if (i1 !== 6'b000001) begin miscompares++; $display("FAIL presc_int: got %b expected 000001", i1); end
        wr(A_LOAD, 32'd3, 4'hF);
        wr(A_CTRL, 32'd1, 4'hF);
        repeat (5) advance();
        rd(A_COUNT);
        vectors++;
        if (d1 !== 32'd2) begin miscompares++; $display("FAIL presc_midcount: got %0d expected 2", d1); end
        // Reset asserted between clock edges must clear everything at once.
        rst = 0;
        model_reset();
        #1;
        vectors++;
        if (i0 !== 6'd0 || i1 !== 6'd0) begin
            miscompares++;
            $display("FAIL async_rst_int: got %b/%b expected 0", i0, i1);
        end
        vectors++;
        if (d1 !== 32'd0) begin miscompares++; $display("FAIL async_rst_count: got %0d expected 0", d1); end
        bus_idle();
        @(negedge clk);
        rst = 1;
        advance();
    endtask

    task automatic test_random();
        logic [31:0] offs [8];
        logic [31:0] off, a, exp0, exp1;
        logic        exp_hit;
        int          op;
        offs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'hFC};
        do_reset();
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 5) == 0) ext = 4'($urandom);
            off = offs[$urandom_range(0, 7)];
            case ($urandom_range(0, 9))
                0:       a = 32'h1000_0100 | off;
                1:       a = 32'h2000_0000 | off;
                default: a = BASE | off | 32'($urandom_range(0, 3));
            endcase
            op = $urandom_range(0, 3);
            if (op == 0) begin
                bus_idle();
            end else if (op == 1) begin
                rd(a);
                exp0 = model_data(0);
                exp1 = model_data(1);
                exp_hit = model_hit();
                vectors++;
                if (d0 !== exp0 || d1 !== exp1 || h0 !== exp_hit || h1 !== exp_hit) begin
                    miscompares++;
                    $display("FAIL rand_read @%h: got %h/%h hit %b/%b expected %h/%h hit %b",
                             a, d0, d1, h0, h1, exp0, exp1, exp_hit);
                end
            end else begin
                ce = ($urandom_range(0, 7) != 0);
                we = 1;
                addr = a;
                sel = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom);
                wdata = (off == 32'h04) ? 32'($urandom_range(0, 6)) : $urandom;
            end
            advance();
            vectors++;
            if (i0 !== {1'b0, m_int[0]} || i1 !== {1'b0, m_int[1]}) begin
                miscompares++;
                $display("FAIL rand_int cycle %0d: got %b/%b expected %b/%b",
                         n, i0, i1, {1'b0, m_int[0]}, {1'b0, m_int[1]});
            end
        end
        bus_idle();
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_autoreload();
        test_ext_edge();
        test_byte_w1c();
        test_prescaler_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mmio_timer_intc.md
Name: mmio_timer_intc

Overview:
- Memory-mapped responder on the core's data-memory bus (addr/data/we/sel/ce), decoded at BASE_ADDR alongside data RAM.
- Contains a programmable down-counting timer and a 5-source interrupt pending/mask unit.
- Drives the core's 6-bit hardware interrupt input (int_o → CPU int_i).
- Read data is combinational because the core's MEM stage samples in the same cycle. All register state is sequential.

Parameters:
- BASE_ADDR, 32'h1000_0000, block base; hit when addr_i[31:8] == BASE_ADDR[31:8].
- PRESCALE, 1, clock cycles per timer tick (legal range ≥1, ≤65535).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ce_i  in  1  bus access enable.
- we_i  in  1  1=write, 0=read.
- addr_i  in  32  byte address; bits [1:0] ignored.
- sel_i  in  4  byte enables for writes; sel_i[3] = bits 31:24.
- data_i  in  32  write data.
- data_o  out  32  read data (combinational).
- hit_o  out  1  ce_i && address in block window (combinational), used by the system read mux.
- ext_irq_i  in  4  asynchronous external interrupt lines, active-high.
- int_o  out  6  interrupt request to core, registered.

Behaviour:
- Register map (offset = addr_i[7:0]):
  - 0x00 CTRL (RW): bit0 EN, bit1 AUTO; other bits read 0.
  - 0x04 LOAD (RW, 32b).
  - 0x08 COUNT (RO).
  - 0x0C PEND (W1C): bit0 timer, bits4:1 ext[3:0].
  - 0x10 MASK (RW, bits4:0).
  - 0x14 RAW (RO): bits3:0 synchronized ext levels.
- Unmapped offsets: read 0, writes ignored.
- Writes occur on the rising edge when ce_i && we_i && hit. Only bytes with sel_i set are updated. Writes to RO registers are ignored.
- data_o = selected register when ce_i && !we_i && hit; otherwise 32'h0.
- Reset (rst==0, async): CTRL, LOAD, COUNT, PEND, MASK, prescale counter and synchronizers all clear to 0. int_o = 0. data_o follows its combinational rule.
- Write to LOAD: COUNT <= new LOAD value (after byte merge) on the same edge. The prescale counter is cleared.
- Prescaler:
  - While EN=0 the counter is held at 0.
  - While EN=1 it counts 0..PRESCALE-1 and asserts tick when it equals PRESCALE-1, then wraps to 0.
  - PRESCALE=1 gives a tick every cycle.
- Timer on each tick with COUNT != 0:
  - COUNT > 1: COUNT <= COUNT-1.
  - COUNT == 1 (expiry): PEND[0] <= 1.
    - If AUTO=1: COUNT <= LOAD and EN stays set.
    - If AUTO=0: COUNT <= 0 and EN <= 0.
- COUNT == 0 with EN=1: idle, no expiry, no wrap. Writing EN=1 while COUNT==0 does not reload.
- External sources:
  - ext_irq_i passes through a 2-flop synchronizer, then a rising-edge detector (sync vs. delayed copy).
  - A rising edge sets PEND[i+1], 3 cycles after the input rises.
  - Levels alone do not re-set PEND.
- PEND write: bits written 1 (with byte enabled) clear. A hardware set in the same cycle wins, so the bit stays 1.
- Simultaneous LOAD write and expiry: COUNT takes the written value. PEND[0] is still set. The AUTO reload is overridden by the write.
- Simultaneous CTRL write and tick: the CTRL write wins for EN. The tick's COUNT update still applies using the pre-write EN.
- int_o[4:0] <= PEND & MASK, registered, so there is 1 cycle of latency after PEND/MASK change. int_o[5] is tied 0.
- Reset mid-count: all state clears immediately and the timer stops. A pending edge is lost.

Test Plan:
- Reset check: after reset, read 0x00, 0x04, 0x08, 0x0C, 0x10 → all 0; int_o=0. Read 0x1000_0100 → hit_o=0, data_o=0.
- One-shot expiry:
  - Stimulus: PRESCALE=1; write LOAD=5, MASK=1, CTRL=1.
  - COUNT reads 5,4,3,2,1 on successive cycles after EN.
  - On the 5th tick: COUNT=0, PEND=1, CTRL.EN=0. int_o=6'b000001 one cycle later.
- Auto-reload: LOAD=3, CTRL=3 → PEND[0] sets every 3 ticks and COUNT reloads to 3. W1C PEND=1 clears it; int_o drops the next cycle.
- External edge: MASK=5'h1E; pulse ext_irq_i[2] high for 10 cycles → PEND=5'b01000 three cycles after the rise, set once only. RAW bit2=1 during the pulse. int_o[3]=1.
- Byte writes and W1C race:
  - Write LOAD=32'hAABBCCDD with sel=4'b0011 over 0 → LOAD=32'h0000CCDD.
  - W1C PEND[0] on the same cycle as an expiry → PEND[0] remains 1.
- Prescaler and async reset:
  - PRESCALE=4, LOAD=2, EN=1 → expiry 8 cycles after the enable edge.
  - Assert rst mid-count → COUNT=0 and int_o=0 immediately, with no clock edge required.
